ras_call_detect: RTL and testbench
==================================

RAS_CALL_DETECT -- requirements
Module: ras_call_detect

Interface
REQ-001 The block SHALL have parameter WIDTH, default 31, meaning return-address width in halfword units (PC[WIDTH:1]).
REQ-002 The block SHALL have parameter SKID, default 1, meaning 1 = 2-entry skid buffer and 0 = single output register.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_ni  in  1  asynchronous active-low reset.
REQ-004 flush_i  in  1  discards all held entries; any input in the same cycle is dropped.
REQ-005 in_valid_i  in  1  instruction valid; in_ready_o  out  1  block can accept.
REQ-006 in_pc_i  in  WIDTH  halfword PC of the instruction; in_instr_i  in  32  raw instruction, low half only when compressed.
REQ-007 out_valid_o  out  1  entry pending; out_ready_i  in  1  downstream RAS consumes.
REQ-008 push_o  out  1  push pulse; pop_o  out  1  pop pulse; din_o  out  WIDTH  return address to push.

Function
REQ-009 Decode SHALL classify the input as NONE, PUSH, POP or POPPUSH; link = x1 or x5.
REQ-010 JAL SHALL give PUSH when rd is link, else NONE.
REQ-011 JALR rd!link/rs1!link SHALL give NONE; rd!link/rs1 link POP; rd link/rs1!link PUSH; both link with rd!=rs1 POPPUSH; both link with rd==rs1 PUSH.
REQ-012 Any other opcode SHALL give NONE, and NONE entries SHALL still flow through the handshake.
REQ-013 Return address SHALL be in_pc_i+2 for 32-bit instructions and in_pc_i+1 for compressed ones, wrapping modulo 2^WIDTH.
REQ-014 Latency: an entry accepted in cycle N SHALL appear on out_valid_o in cycle N+1, with no combinational path from in_* to out_*.
REQ-015 An entry SHALL transfer when out_valid_o && out_ready_i.
REQ-016 push_o and pop_o SHALL be high only in the transfer cycle; POPPUSH SHALL drive both together.
REQ-017 Each transfer SHALL produce exactly one pulse set; while out_valid_o && !out_ready_i, push_o, pop_o and din_o SHALL be held and the pulses SHALL be suppressed.
REQ-018 Skid FSM (SKID=1) SHALL have states EMPTY, ONE and TWO.
REQ-019 in_ready_o SHALL be driven from a register and SHALL be 0 only in state TWO.
REQ-020 A simultaneous accept and transfer in state ONE SHALL keep state ONE.
REQ-021 Entries SHALL leave in FIFO order.
REQ-022 With SKID=0, in_ready_o SHALL equal !out_valid_o || out_ready_i.
REQ-023 flush_i SHALL move the FSM to EMPTY at the next edge and SHALL suppress push_o and pop_o in the flush cycle.
REQ-024 flush_i SHALL take priority over the in/out handshakes.

Reset
REQ-025 Reset SHALL force state EMPTY, out_valid_o=0, push_o=0, pop_o=0, din_o=0 and in_ready_o=1.
REQ-026 Reset asserted mid-transfer SHALL lose the pending entries without emitting any pulse.

Configuration
REQ-027 Macro RAS_COMPRESSED_EN SHALL enable decoding of 16-bit instructions (in_instr_i[1:0]!=2'b11).
REQ-028 With RAS_COMPRESSED_EN defined, decode SHALL give C.JAL -> PUSH, C.JALR rs1=x5 -> POPPUSH, other C.JALR -> PUSH, C.JR with rs1 link -> POP, and +1 return address.
REQ-029 Without RAS_COMPRESSED_EN, every 16-bit encoding SHALL give NONE.

Structure
REQ-030 Package ras_pkg SHALL hold the ras_op_e enum {NONE, PUSH, POP, POPPUSH}, the link register indices and the JAL/JALR/C-quadrant opcode constants.
REQ-031 Combinational decode SHALL live in sub-module ras_call_decode (instr -> op, is_compressed); the FSM and storage SHALL be in ras_call_detect.

Verification
REQ-032 jal x1 at pc=0x100, out_ready_i=1 -> next cycle push_o=1, pop_o=0, din_o=0x102.
REQ-033 jalr x1,x5 -> push_o=pop_o=1 in one cycle; jalr x0,0(x1) -> pop_o only; jalr x0,0(x6) -> no pulse, out_valid_o=1.
REQ-034 Three back-to-back calls with out_ready_i=0 -> in_ready_o=0 after two; after out_ready_i rises -> exactly three pushes in order, none dropped or duplicated.
REQ-035 pc=2^31-1 with 32-bit call -> din_o=1 (wrap).
REQ-036 flush_i in state TWO with in_valid_i=1 -> no pulse that cycle, EMPTY next, flushed and dropped entries never appear.
REQ-037 With RAS_COMPRESSED_EN: c.jalr x5 at pc=0x40 -> push+pop, din_o=0x41; without the macro -> no pulse.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared types and encoding constants for the return-address-stack call
// detector: operation and skid-state enums, link register indices and the
// RISC-V opcode fields the decoder matches on.
package ras_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PUSH    = 2'd1,
        POP     = 2'd2,
        POPPUSH = 2'd3
    } ras_op_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } ras_state_e;

    localparam logic [4:0] LINK_X1 = 5'd1;
    localparam logic [4:0] LINK_X5 = 5'd5;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam logic [1:0] C_Q1 = 2'b01;
    localparam logic [1:0] C_Q2 = 2'b10;

    localparam logic [2:0] C_F3_JAL  = 3'b001;
    localparam logic [3:0] C_F4_JR   = 4'b1000;
    localparam logic [3:0] C_F4_JALR = 4'b1001;

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_X1) || (r == LINK_X5);
    endfunction

    function automatic logic op_pushes(input ras_op_e op);
        return (op == PUSH) || (op == POPPUSH);
    endfunction

    function automatic logic op_pops(input ras_op_e op);
        return (op == POP) || (op == POPPUSH);
    endfunction

endpackage

// File: rtl/ras_call_decode.sv
// Purely combinational classifier: turns a raw instruction into a RAS
// operation and reports whether it is a 16-bit encoding. Decoding of the
// compressed forms is only present when RAS_COMPRESSED_EN is defined;
// otherwise every 16-bit encoding classifies as NONE.
module ras_call_decode
    import ras_pkg::*;
(
    input  logic [31:0] instr_i,
    output ras_op_e     op_o,
    output logic        is_compressed_o
);

    logic [4:0] rd;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic       unused_imm;

    assign rd              = instr_i[11:7];
    assign rs1             = instr_i[19:15];
    assign funct3          = instr_i[14:12];
    assign is_compressed_o = (instr_i[1:0] != 2'b11);
    assign unused_imm      = ^instr_i[31:20];

`ifdef RAS_COMPRESSED_EN
    logic [4:0] c_rs2;
    assign c_rs2 = instr_i[6:2];
`endif

    // Classify the instruction by link-register usage of rd/rs1.
    always_comb begin
        op_o = NONE;
        if (!is_compressed_o) begin
            if (instr_i[6:0] == OPC_JAL) begin
                op_o = is_link(rd) ? PUSH : NONE;
            end else if (instr_i[6:0] == OPC_JALR && funct3 == 3'b000) begin
                case ({is_link(rd), is_link(rs1)})
                    2'b01:   op_o = POP;
                    2'b10:   op_o = PUSH;
                    2'b11:   op_o = (rd != rs1) ? POPPUSH : PUSH;
                    default: op_o = NONE;
                endcase
            end
        end
`ifdef RAS_COMPRESSED_EN
        else begin
            if (instr_i[1:0] == C_Q1 && instr_i[15:13] == C_F3_JAL) begin
                op_o = PUSH;
            end else if (instr_i[1:0] == C_Q2 && rd != 5'd0 && c_rs2 == 5'd0) begin
                if (instr_i[15:12] == C_F4_JALR) begin
                    op_o = (rd == LINK_X5) ? POPPUSH : PUSH;
                end else if (instr_i[15:12] == C_F4_JR) begin
                    op_o = is_link(rd) ? POP : NONE;
                end
            end
        end
`endif
    end

endmodule

// File: rtl/ras_call_detect.sv
// Call/return detector feeding a return-address stack. Instructions are
// decoded, their return address computed, and the result held in a skid
// buffer (SKID=1, two entries) or a single output register (SKID=0).
// push_o/pop_o pulse only in the cycle an entry is consumed downstream.
// Optional feature macro: RAS_COMPRESSED_EN (16-bit call/return decode).
module ras_call_detect
    import ras_pkg::*;
#(
    parameter int WIDTH = 31,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_pc_i,
    input  logic [31:0]      in_instr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             push_o,
    output logic             pop_o,
    output logic [WIDTH-1:0] din_o
);

    localparam logic [WIDTH-1:0] RET_STEP_C  = WIDTH'(1);
    localparam logic [WIDTH-1:0] RET_STEP_32 = WIDTH'(2);

    ras_state_e       state_q, state_d;
    logic             ready_q, ready_d;
    ras_op_e          op0_q, op0_d, op1_q, op1_d;
    logic [WIDTH-1:0] ret0_q, ret0_d, ret1_q, ret1_d;

    ras_op_e          dec_op;
    logic             dec_is_c;
    logic [WIDTH-1:0] dec_ret;
    logic             accept;
    logic             transfer;

    ras_call_decode u_decode (
        .instr_i         (in_instr_i),
        .op_o            (dec_op),
        .is_compressed_o (dec_is_c)
    );

    assign dec_ret  = in_pc_i + (dec_is_c ? RET_STEP_C : RET_STEP_32);
    assign accept   = in_valid_i && in_ready_o && !flush_i;
    assign transfer = out_valid_o && out_ready_i && !flush_i;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready_o = ready_q;
        end else begin : g_single
            assign in_ready_o = !out_valid_o || out_ready_i;
        end
    endgenerate

    // State and registered ready; reset empties the buffer and opens the input.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Next state: occupancy follows accepts and transfers; flush wins over both.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) state_d = ONE;
            end
            ONE: begin
                if (accept && !transfer && SKID != 0) state_d = TWO;
                else if (!accept && transfer)         state_d = EMPTY;
            end
            TWO: begin
                if (transfer) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
        if (flush_i) state_d = EMPTY;
        ready_d = (state_d != TWO);
    end

    // Outputs: head entry drives din; pulses only on an unflushed transfer.
    always_comb begin
        out_valid_o = (state_q != EMPTY);
        din_o       = ret0_q;
        push_o      = transfer && op_pushes(op0_q);
        pop_o       = transfer && op_pops(op0_q);
    end

    // Entry storage: slot 0 is the head, slot 1 the skid entry behind it.
    always_comb begin
        op0_d  = op0_q;
        ret0_d = ret0_q;
        op1_d  = op1_q;
        ret1_d = ret1_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    op0_d  = dec_op;
                    ret0_d = dec_ret;
                end
            end
            ONE: begin
                if (accept && transfer) begin
                    op0_d  = dec_op;
                    ret0_d = dec_ret;
                end else if (accept) begin
                    op1_d  = dec_op;
                    ret1_d = dec_ret;
                end
            end
            TWO: begin
                if (transfer) begin
                    op0_d  = op1_q;
                    ret0_d = ret1_q;
                end
            end
            default: begin
                op0_d = NONE;
            end
        endcase
    end

    // Entry registers.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            op0_q  <= NONE;
            ret0_q <= '0;
            op1_q  <= NONE;
            ret1_q <= '0;
        end else begin
            op0_q  <= op0_d;
            ret0_q <= ret0_d;
            op1_q  <= op1_d;
            ret1_q <= ret1_d;
        end
    end

endmodule

// File: tb/tb_ras_call_detect.sv
// Bench for ras_call_detect: directed instructions with hand-computed
// expected pulses/return addresses go into a queue when accepted; a
// negedge monitor pops and compares on every downstream transfer and
// checks that no pulse appears outside a transfer.
module tb_ras_call_detect;

    localparam int WIDTH = 31;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic [WIDTH-1:0] in_pc_i = '0;
    logic [31:0]      in_instr_i = '0;
    logic             out_ready_i = 1'b0;
    logic             in_ready_o;
    logic             out_valid_o;
    logic             push_o;
    logic             pop_o;
    logic [WIDTH-1:0] din_o;

    typedef struct {
        string            name;
        logic             exp_push;
        logic             exp_pop;
        logic [WIDTH-1:0] exp_din;
        logic             chk_din;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    ras_call_detect #(.WIDTH(WIDTH), .SKID(1)) dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_pc_i     (in_pc_i),
        .in_instr_i  (in_instr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .push_o      (push_o),
        .pop_o       (pop_o),
        .din_o       (din_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one instruction until accepted, then records its expected transfer.
    task automatic applyStimulus(input string name, input logic [31:0] instr,
                                 input logic [WIDTH-1:0] pc, input logic ep, input logic eo,
                                 input logic [WIDTH-1:0] ed, input logic cd);
        exp_t e;
        int   n;
        in_valid_i = 1'b1;
        in_instr_i = instr;
        in_pc_i    = pc;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready_o && !flush_i) break;
            n++;
            if (n >= 100) begin
                total++;
                bad++;
                $display("[TB] FAIL %s_accept: in_ready_o stayed 0 for %0d cycles, required 1", name, n);
                in_valid_i = 1'b0;
                return;
            end
        end
        e.name = name; e.exp_push = ep; e.exp_pop = eo; e.exp_din = ed; e.chk_din = cd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        checkOutput({name, "_lat_valid"}, 32'(out_valid_o), 32'd1);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput({name, "_drain_left"}, exp_q.size(), 32'd0);
    endtask

    // Scoreboard monitor: compare on transfers, forbid pulses otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst_ni) begin
            if (out_valid_o && out_ready_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_transfer: push=%0b pop=%0b din=0x%0h, required no entry", push_o, pop_o, din_o);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput({e.name, "_push"}, 32'(push_o), 32'(e.exp_push));
                    checkOutput({e.name, "_pop"}, 32'(pop_o), 32'(e.exp_pop));
                    if (e.chk_din) checkOutput({e.name, "_din"}, 32'(din_o), 32'(e.exp_din));
                end
            end else begin
                checkOutput("idle_push", 32'(push_o), 32'd0);
                checkOutput("idle_pop", 32'(pop_o), 32'd0);
            end
        end
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("rst_push", 32'(push_o), 32'd0);
        checkOutput("rst_pop", 32'(pop_o), 32'd0);
        checkOutput("rst_din", 32'(din_o), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        out_ready_i = 1'b1;

        // Streaming 32-bit decode with downstream always ready
        applyStimulus("jal_x1",        32'h000000EF, 31'h100, 1'b1, 1'b0, 31'h102, 1'b1);
        applyStimulus("jalr_x1_x5",    32'h000280E7, 31'h110, 1'b1, 1'b1, 31'h112, 1'b1);
        applyStimulus("jalr_x0_x1",    32'h00008067, 31'h120, 1'b0, 1'b1, 31'h122, 1'b1);
        applyStimulus("jalr_x0_x6",    32'h00030067, 31'h130, 1'b0, 1'b0, 31'h132, 1'b1);
        applyStimulus("jal_x5",        32'h000002EF, 31'h140, 1'b1, 1'b0, 31'h142, 1'b1);
        applyStimulus("jal_x0",        32'h0000006F, 31'h150, 1'b0, 1'b0, 31'h152, 1'b1);
        applyStimulus("jalr_x1_x1",    32'h000080E7, 31'h160, 1'b1, 1'b0, 31'h162, 1'b1);
        applyStimulus("jalr_x5_x1",    32'h000082E7, 31'h170, 1'b1, 1'b1, 31'h172, 1'b1);
        applyStimulus("jalr_x1_x6",    32'h000300E7, 31'h180, 1'b1, 1'b0, 31'h182, 1'b1);
        applyStimulus("addi_x1",       32'h00008093, 31'h190, 1'b0, 1'b0, 31'h192, 1'b1);
        applyStimulus("jal_x1_wrap",   32'h000000EF, 31'h7FFFFFFF, 1'b1, 1'b0, 31'h1, 1'b1);
        waitDrain("stream");

        // Compressed encodings
`ifdef RAS_COMPRESSED_EN
        applyStimulus("c_jalr_x5",     32'h00009282, 31'h40, 1'b1, 1'b1, 31'h41, 1'b1);
        applyStimulus("c_jal",         32'h00002001, 31'h50, 1'b1, 1'b0, 31'h51, 1'b1);
        applyStimulus("c_jr_x1",       32'h00008082, 31'h60, 1'b0, 1'b1, 31'h61, 1'b1);
        applyStimulus("c_jr_x6",       32'h00008302, 31'h70, 1'b0, 1'b0, 31'h71, 1'b1);
        applyStimulus("c_jalr_x1",     32'h00009082, 31'h80, 1'b1, 1'b0, 31'h81, 1'b1);
`else
        applyStimulus("c_jalr_x5",     32'h00009282, 31'h40, 1'b0, 1'b0, 31'h41, 1'b0);
        applyStimulus("c_jal",         32'h00002001, 31'h50, 1'b0, 1'b0, 31'h51, 1'b0);
        applyStimulus("c_jr_x1",       32'h00008082, 31'h60, 1'b0, 1'b0, 31'h61, 1'b0);
        applyStimulus("c_jalr_x1",     32'h00009082, 31'h80, 1'b0, 1'b0, 31'h81, 1'b0);
`endif
        waitDrain("compressed");

        // Backpressure: two fill the skid buffer, third waits, all three drain in order
        out_ready_i = 1'b0;
        applyStimulus("bp_call0", 32'h000000EF, 31'h200, 1'b1, 1'b0, 31'h202, 1'b1);
        applyStimulus("bp_call1", 32'h000000EF, 31'h210, 1'b1, 1'b0, 31'h212, 1'b1);
        checkOutput("bp_in_ready_full", 32'(in_ready_o), 32'd0);
        checkOutput("bp_hold_din", 32'(din_o), 32'h202);
        fork
            applyStimulus("bp_call2", 32'h000000EF, 31'h220, 1'b1, 1'b0, 31'h222, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                checkOutput("bp_hold_din_late", 32'(din_o), 32'h202);
                out_ready_i = 1'b1;
            end
        join
        waitDrain("backpressure");

        // Flush in state TWO with an incoming instruction and downstream ready
        out_ready_i = 1'b0;
        applyStimulus("fl2_call0", 32'h000000EF, 31'h300, 1'b1, 1'b0, 31'h302, 1'b1);
        applyStimulus("fl2_call1", 32'h000000EF, 31'h310, 1'b1, 1'b0, 31'h312, 1'b1);
        out_ready_i = 1'b1;
        flush_i     = 1'b1;
        in_valid_i  = 1'b1;
        in_instr_i  = 32'h000000EF;
        in_pc_i     = 31'h320;
        @(negedge clk);
        checkOutput("fl2_push", 32'(push_o), 32'd0);
        checkOutput("fl2_pop", 32'(pop_o), 32'd0);
        @(posedge clk);
        #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        exp_q.delete();
        checkOutput("fl2_out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("fl2_in_ready", 32'(in_ready_o), 32'd1);
        repeat (4) @(posedge clk);
        #1;

        // Flush in state ONE drops the same-cycle input
        out_ready_i = 1'b0;
        applyStimulus("fl1_call0", 32'h000000EF, 31'h330, 1'b1, 1'b0, 31'h332, 1'b1);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_pc_i    = 31'h340;
        @(posedge clk);
        #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        exp_q.delete();
        checkOutput("fl1_out_valid", 32'(out_valid_o), 32'd0);
        out_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        applyStimulus("post_flush", 32'h000280E7, 31'h350, 1'b1, 1'b1, 31'h352, 1'b1);
        waitDrain("post_flush");

        // Asynchronous reset while an entry is pending
        out_ready_i = 1'b0;
        applyStimulus("rst_mid_call", 32'h000000EF, 31'h360, 1'b1, 1'b0, 31'h362, 1'b1);
        out_ready_i = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("rstmid_push", 32'(push_o), 32'd0);
        checkOutput("rstmid_pop", 32'(pop_o), 32'd0);
        checkOutput("rstmid_out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("rstmid_din", 32'(din_o), 32'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        checkOutput("rstmid_in_ready", 32'(in_ready_o), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus("post_rst", 32'h00008067, 31'h370, 1'b0, 1'b1, 31'h372, 1'b1);
        waitDrain("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
